// File: rtl/tile_dispatch_scheduler.sv
// tile_dispatch_scheduler: runs one frame through the tiler, buffers its
// descriptor stream and hands tiles out round-robin to idle compute engines.
module tile_dispatch_scheduler #(
    parameter int WIDTH      = 16,
    parameter int NUM_ENG    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_start_i,
    output logic               tiler_start_o,
    input  logic               tile_valid_i,
    input  logic [WIDTH-1:0]   tile_row_idx_i,
    input  logic [WIDTH-1:0]   tile_col_idx_i,
    input  logic [WIDTH-1:0]   tile_rows_i,
    input  logic [WIDTH-1:0]   tile_cols_i,
    input  logic               tiler_done_i,
    output logic [NUM_ENG-1:0] eng_start_o,
    output logic [WIDTH-1:0]   eng_row_idx_o,
    output logic [WIDTH-1:0]   eng_col_idx_o,
    output logic [WIDTH-1:0]   eng_rows_o,
    output logic [WIDTH-1:0]   eng_cols_o,
    input  logic [NUM_ENG-1:0] eng_done_i,
    output logic               busy_o,
    output logic               frame_done_o,
    output logic               overflow_o,
    output logic [WIDTH-1:0]   tiles_dispatched_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = $clog2(NUM_ENG);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    typedef struct packed {
        logic [WIDTH-1:0] row;
        logic [WIDTH-1:0] col;
        logic [WIDTH-1:0] rows;
        logic [WIDTH-1:0] cols;
    } desc_t;

    logic [1:0]         state_q, state_d;
    desc_t              fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q;
    logic [NUM_ENG-1:0] eng_busy_q, eng_start_q, grant, done_acc;
    logic [EW-1:0]      rr_q, grant_idx;
    logic               grant_vld;
    desc_t              bus_q;
    logic [WIDTH-1:0]   disp_q, comp_q, n_done;
    logic               seen_q, ovf_q;
    logic               fifo_empty, fifo_full, push_req, push, pop;
    logic               start_frame, frame_complete;

    assign fifo_empty  = (count_q == '0);
    assign fifo_full   = (count_q == (AW+1)'(FIFO_DEPTH));
    assign start_frame = (state_q == S_IDLE) && frame_start_i;

    // done pulses from engines that are not busy are stray and dropped here
    assign done_acc = eng_done_i & eng_busy_q;

    // the tiler cannot be stalled, so a push into a full FIFO is lost unless a pop frees a slot
    assign push_req = tile_valid_i && ((state_q == S_LAUNCH) || (state_q == S_RUN));
    assign push     = push_req && (!fifo_full || pop);
    assign pop      = grant_vld;

    // tiler_done is taken live as well as latched so a level or a pulse both work
    assign frame_complete = (seen_q || tiler_done_i) && fifo_empty &&
                            (eng_busy_q == '0) && (disp_q == comp_q);

    // round-robin search from rr over the registered busy flags
    always_comb begin
        logic [EW-1:0] cand;
        cand      = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_ENG; k++) begin
            cand = EW'((int'(rr_q) + k) % NUM_ENG);
            if (!grant_vld && !fifo_empty && !eng_busy_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        grant = grant_vld ? (NUM_ENG'(1) << grant_idx) : '0;
    end

    // several engines may finish in the same cycle
    always_comb begin
        n_done = '0;
        for (int k = 0; k < NUM_ENG; k++)
            n_done = n_done + WIDTH'(done_acc[k]);
    end

    // frame sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (frame_start_i) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_RUN;
            S_RUN:    if (frame_complete) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // descriptor storage; contents need no reset, only the pointers do
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= desc_t'{tile_row_idx_i, tile_col_idx_i, tile_rows_i, tile_cols_i};
    end

    // control, FIFO pointers, engine tracking and frame counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            eng_busy_q  <= '0;
            eng_start_q <= '0;
            rr_q        <= '0;
            bus_q       <= '0;
            disp_q      <= '0;
            comp_q      <= '0;
            seen_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q     <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            eng_busy_q  <= (eng_busy_q & ~done_acc) | grant;
            eng_start_q <= grant;
            if (pop) begin
                bus_q <= fifo_mem[rd_ptr_q];
                rr_q  <= (grant_idx == EW'(NUM_ENG - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (start_frame) begin
                disp_q <= '0;
                comp_q <= '0;
                seen_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                disp_q <= disp_q + WIDTH'(pop);
                comp_q <= comp_q + n_done;
                if ((state_q == S_RUN) && tiler_done_i) seen_q <= 1'b1;
                if (push_req && !push) ovf_q <= 1'b1;
            end
        end
    end

    assign tiler_start_o      = (state_q == S_LAUNCH);
    assign frame_done_o       = (state_q == S_DONE);
    assign busy_o             = (state_q != S_IDLE);
    assign overflow_o         = ovf_q;
    assign tiles_dispatched_o = disp_q;
    assign eng_start_o        = eng_start_q;
    assign eng_row_idx_o      = bus_q.row;
    assign eng_col_idx_o      = bus_q.col;
    assign eng_rows_o         = bus_q.rows;
    assign eng_cols_o         = bus_q.cols;

endmodule

// File: doc/tile_dispatch_scheduler.md
# tile_dispatch_scheduler

Sequences one frame through `frame_tiler` and shares the resulting tiles among `NUM_ENG` compute engines. On `frame_start` it pulses the tiler's `start` and buffers the tiler's descriptor stream in a small FIFO, because the tiler has no backpressure. It dispatches each tile to an idle engine using round-robin arbitration, and pulses `frame_done` once every tile has been completed. It sits between `frame_tiler` and the engine array.

## Interface
- `WIDTH`, 16: width of tile coordinates, sizes and counters.
- `NUM_ENG`, 4: number of compute engines; must be ≥ 2.
- `FIFO_DEPTH`, 8: descriptor FIFO entries; must be a power of 2.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle request to process a frame.
- `tiler_start`  out  1  one-cycle start pulse to `frame_tiler`.
- `tile_valid`  in  1  tiler descriptor valid.
- `tile_row_idx`, `tile_col_idx`  in  WIDTH each  tile origin.
- `tile_rows`, `tile_cols`  in  WIDTH each  tile size.
- `tiler_done`  in  1  tiler finished; treated as a level or a pulse.
- `eng_start`  out  NUM_ENG  one-hot dispatch pulse.
- `eng_row_idx`, `eng_col_idx`, `eng_rows`, `eng_cols`  out  WIDTH each  shared descriptor bus; valid only while `eng_start` is non-zero.
- `eng_done`  in  NUM_ENG  per-engine completion pulse.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle frame completion pulse.
- `overflow`  out  1  sticky; a descriptor was dropped.
- `tiles_dispatched`  out  WIDTH  dispatches in the current frame.

## Operation
- States:
  - IDLE: `frame_start` → LAUNCH.
  - LAUNCH: `tiler_start` = 1 for exactly this cycle → RUN.
  - RUN: latches `tiler_done`. Once `tiler_done` has been latched, FIFO is empty and all engines are idle → DONE.
  - DONE: `frame_done` = 1 for this cycle → IDLE.
- Entering LAUNCH clears:
  - the `tiler_done` latch
  - `tiles_dispatched` and the completed counter
  - `overflow`
- `frame_start` outside IDLE is ignored.
- FIFO push:
  - Occurs on `tile_valid` in RUN or LAUNCH.
  - Push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise the descriptor is dropped and `overflow` is set.
  - `tile_valid` in IDLE or DONE is ignored.
- Busy tracking:
  - `eng_busy[i]` is set at the edge where `eng_start[i]` is issued.
  - It is cleared by `eng_done[i]`.
  - `eng_done[i]` while `eng_busy[i]` = 0 is ignored.
- Arbitration:
  - A pointer `rr` holds the engine after the last grant; it is 0 after reset.
  - Search idle engines starting at `rr`, wrapping modulo `NUM_ENG`.
  - Grant the first idle engine found.
  - At most one dispatch per cycle, and only while FIFO is non-empty.
- Same-cycle `eng_done[i]` and dispatch: eligibility uses the registered `eng_busy`. Engine i is therefore not eligible in the cycle its done arrives; it becomes eligible the next cycle.
- Completion requires dispatched == completed. Both counters are WIDTH bits and wrap silently.
- Counting: `tiles_dispatched` increments on each dispatch. The completed counter increments on each accepted `eng_done`.

## Timing
- Reset values:
  - state IDLE; `tiler_start`, `frame_done`, `busy` and `overflow` all 0.
  - `eng_start` 0; descriptor bus 0; `tiles_dispatched` 0.
  - FIFO empty; `eng_busy` all 0; `rr` 0.
- `rst` mid-frame: aborts the frame and returns to the reset values. No `frame_done` is generated. Outstanding `eng_done` pulses after reset are ignored.
- Latency:
  - `frame_start` sampled at edge k → `tiler_start` high in cycle k+1.
  - Descriptor sampled at edge k → earliest `eng_start` in cycle k+2. The descriptor bus is registered together with `eng_start`.
- Throughput: with idle engines available, one dispatch per cycle.
- `frame_done` is asserted exactly one cycle after the completion condition is met.
- A frame with zero tiles (`tiler_done`, no `tile_valid`) goes LAUNCH → RUN → DONE. `frame_done` is pulsed and `tiles_dispatched` = 0.

## Test plan
- Tiler H=10, W=14, rows=4, cols_max=5; 4 engines, each `eng_done` 3 cycles after `eng_start` → 9 `eng_start` pulses, each one-hot. First four grants go to engines 0, 1, 2, 3. `tiles_dispatched` = 9, one `frame_done` pulse, `overflow` = 0.
- Engines never complete; 13 back-to-back `tile_valid` → 4 dispatches, 8 descriptors held, exactly 1 dropped, `overflow` = 1. Releasing all engines then drains every held tile, followed by `frame_done`.
- `eng_done[2]` in the same cycle the arbiter would pick engine 2 → engine 3 is granted. Engine 2 becomes eligible the following cycle.
- Spurious `eng_done[1]` while engine 1 is idle → counters unchanged. No early `frame_done`.
- `frame_start` during RUN → ignored, no second `tiler_start`. `rst` asserted mid-RUN for 1 cycle → all outputs return to reset values and no `frame_done`. A new `frame_start` then runs a frame normally.
- Zero-tile frame → `frame_done` 3 cycles after `frame_start`, `tiles_dispatched` = 0.
